// File: rtl/vec_mem_pkg.sv
// Shared types and defaults for the vector MEM-stage sequencer.
package vec_mem_pkg;

   localparam int DW_DEF     = 32;
   localparam int AW_DEF     = 32;
   localparam int LANES_DEF  = 4;
   localparam int STRIDE_DEF = 4;

   typedef enum logic [2:0] {
      IDLE,
      STORE,
      LOAD,
      LWAIT,
      DONE
   } state_t;

   // Number of memory beats an access takes: one per lane for vectors.
   function automatic int unsigned beat_cnt(input logic is_vec, input int unsigned lanes);
      return is_vec ? lanes : 32'd1;
   endfunction

endpackage

// File: rtl/vec_mem_sequencer_if.sv
// Single-port, one-word-wide data memory bus.
interface vec_mem_sequencer_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic          mem_re;
   logic [DW-1:0] mem_rdata;

   modport master (
      output mem_addr, mem_wdata, mem_we, mem_re,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_we, mem_re,
      output mem_rdata
   );
endinterface

// File: rtl/lane_capture.sv
// One load lane: DW-wide holding register, loaded on en, cleared by reset.
module lane_capture #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);

   // Hold between loads; only a capture strobe may change the lane.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/vec_mem_sequencer.sv
// MEM-stage sequencer: serialises vector/scalar loads and stores onto a
// one-word memory port, stalls upstream while beats are in flight and
// collects load lanes for writeback.
module vec_mem_sequencer
   import vec_mem_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int AW     = AW_DEF,
   parameter int LANES  = LANES_DEF,
   parameter int STRIDE = STRIDE_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_mem,
   input  logic                  rd_mem,
   input  logic                  is_vec,
   input  logic [AW-1:0]         base_addr,
   input  logic [LANES*DW-1:0]   wdata,
   vec_mem_sequencer_if.master   mem,
   output logic [LANES*DW-1:0]   rdata,
   output logic                  stall,
   output logic                  done
);

   localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;

   state_t                    state, state_nx;
   logic [KW-1:0]             k, k_nx;
   logic [KW-1:0]             last_k;
   logic                      acc;
   logic [AW-1:0]             beat_addr;
   logic [LANES-1:0][DW-1:0]  wlane;
   logic [LANES-1:0][DW-1:0]  rlane;
   logic [LANES-1:0]          cap_en;

   assign acc       = wr_mem | rd_mem;
   assign last_k    = KW'(beat_cnt(is_vec, LANES) - 32'd1);
   // Wraps modulo 2^AW by truncation.
   assign beat_addr = base_addr + AW'(k) * AW'(STRIDE);
   assign wlane     = wdata;
   assign rdata     = rlane;

   // State and beat counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         k     <= '0;
      end else begin
         state <= state_nx;
         k     <= k_nx;
      end
   end

   // Next state, strobes and lane captures. Load data lags its strobe by a
   // cycle, so LOAD beat k captures lane k-1 and LWAIT captures the last lane
   // (k is held at the last beat index through LWAIT for that purpose).
   always_comb begin
      state_nx      = state;
      k_nx          = k;
      stall         = 1'b0;
      done          = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_re    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      cap_en        = '0;
      case (state)
         IDLE: begin
            if (acc) begin
               stall    = 1'b1;
               state_nx = wr_mem ? STORE : LOAD;  // store wins if both set
               k_nx     = '0;
            end
         end
         STORE: begin
            stall         = 1'b1;
            mem.mem_we    = 1'b1;
            mem.mem_addr  = beat_addr;
            mem.mem_wdata = wlane[k];
            if (k == last_k) begin
               state_nx = DONE;
               k_nx     = '0;
            end else begin
               k_nx = k + 1'b1;
            end
         end
         LOAD: begin
            stall        = 1'b1;
            mem.mem_re   = 1'b1;
            mem.mem_addr = beat_addr;
            if (k != '0) cap_en[k - 1'b1] = 1'b1;
            if (k == last_k) state_nx = LWAIT;
            else             k_nx     = k + 1'b1;
         end
         LWAIT: begin
            stall     = 1'b1;
            cap_en[k] = 1'b1;
            state_nx  = DONE;
            k_nx      = '0;
         end
         DONE: begin
            // Pipeline advances on this edge; held inputs are ignored here.
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
            k_nx     = '0;
         end
      endcase
      // Reset forces every output quiet, even with an access on the inputs.
      if (!reset) begin
         stall         = 1'b0;
         done          = 1'b0;
         mem.mem_we    = 1'b0;
         mem.mem_re    = 1'b0;
         mem.mem_addr  = '0;
         mem.mem_wdata = '0;
      end
   end

   // Per-lane load capture registers.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      lane_capture #(.DW(DW)) u_lane (
         .clk   (clk),
         .reset (reset),
         .en    (cap_en[i]),
         .d     (mem.mem_rdata),
         .q     (rlane[i])
      );
   end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer with a one-cycle-latency memory model.
module tb_vec_mem_sequencer;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_mem, rd_mem, is_vec;
   logic [31:0]   base_addr;
   logic [127:0]  wdata;
   logic [127:0]  rdata;
   logic          stall, done;

   vec_mem_sequencer_if #(.AW(32), .DW(32)) mem ();

   vec_mem_sequencer #(.DW(32), .AW(32), .LANES(4), .STRIDE(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_mem    (wr_mem),
      .rd_mem    (rd_mem),
      .is_vec    (is_vec),
      .base_addr (base_addr),
      .wdata     (wdata),
      .mem       (mem),
      .rdata     (rdata),
      .stall     (stall),
      .done      (done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc_cnt  = 0;
   logic scalar_mode = 1'b0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Memory model: data valid one cycle after mem_re.
   always @(posedge clk)
      if (mem.mem_re) mem.mem_rdata <= scalar_mode ? 32'hDEAD : (mem.mem_addr ^ 32'hA5);

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   int          n_we, n_re, cycles, stall_bad, acc_cyc, last_we_cyc;
   logic [31:0] we_addr [8];
   logic [31:0] we_data [8];
   logic [31:0] re_addr [8];

   // Present one access, record strobes until done (bounded), then advance.
   task automatic access(input logic wr, input logic rd, input logic vec,
                         input logic [31:0] base, input logic [127:0] wd);
      wr_mem = wr; rd_mem = rd; is_vec = vec; base_addr = base; wdata = wd;
      n_we = 0; n_re = 0; cycles = 0; stall_bad = 0; acc_cyc = cyc_cnt;
      #1;
      for (int c = 0; c < 20; c++) begin
         cycles = c + 1;
         if (mem.mem_we) begin
            if (n_we < 8) begin we_addr[n_we] = mem.mem_addr; we_data[n_we] = mem.mem_wdata; end
            n_we++;
            last_we_cyc = cyc_cnt;
         end
         if (mem.mem_re) begin
            if (n_re < 8) re_addr[n_re] = mem.mem_addr;
            n_re++;
         end
         if (done) break;
         if (!stall) stall_bad++;
         if (c == 19) cycles = 99;
         @(posedge clk); #1;
      end
      chk("stall_held", stall_bad, 0);
      chk("done_stall_low", stall, 0);
      @(posedge clk); #1;
      wr_mem = 0; rd_mem = 0; is_vec = 0; base_addr = '0; wdata = '0;
      #1;
   endtask

   initial begin
      reset = 1'b0;
      wr_mem = 1'b1; rd_mem = 1'b0; is_vec = 1'b1; base_addr = 32'h10; wdata = '0;
      #3;
      chk("rst_stall", stall, 0);
      chk("rst_done", done, 0);
      chk("rst_we", mem.mem_we, 0);
      chk("rst_addr", mem.mem_addr, 0);
      chk("rst_rdata", rdata, 0);
      wr_mem = 1'b0; is_vec = 1'b0; base_addr = '0;
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      chk("idle_stall", stall, 0);

      // Vector store.
      access(1, 0, 1, 32'h100, {32'h44, 32'h33, 32'h22, 32'h11});
      chk("vst_cycles", cycles, 6);
      chk("vst_nwe", n_we, 4);
      chk("vst_nre", n_re, 0);
      chk("vst_a0", we_addr[0], 32'h100); chk("vst_d0", we_data[0], 32'h11);
      chk("vst_a1", we_addr[1], 32'h104); chk("vst_d1", we_data[1], 32'h22);
      chk("vst_a2", we_addr[2], 32'h108); chk("vst_d2", we_data[2], 32'h33);
      chk("vst_a3", we_addr[3], 32'h10C); chk("vst_d3", we_data[3], 32'h44);
      chk("post_done", done, 0);
      chk("post_stall", stall, 0);

      // Vector load.
      access(0, 1, 1, 32'h200, '0);
      chk("vld_cycles", cycles, 7);
      chk("vld_nre", n_re, 4);
      chk("vld_a0", re_addr[0], 32'h200);
      chk("vld_a3", re_addr[3], 32'h20C);
      chk("vld_rdata", rdata, {32'h2A9, 32'h2AD, 32'h2A1, 32'h2A5});
      @(posedge clk); #1;
      chk("vld_no_reaccept", stall, 0);

      // Scalar load: only lane 0 changes.
      scalar_mode = 1'b1;
      access(0, 1, 0, 32'h40, '0);
      scalar_mode = 1'b0;
      chk("sld_cycles", cycles, 4);
      chk("sld_nre", n_re, 1);
      chk("sld_addr", re_addr[0], 32'h40);
      chk("sld_rdata", rdata, {32'h2A9, 32'h2AD, 32'h2A1, 32'hDEAD});

      // Scalar store.
      access(1, 0, 0, 32'h80, {96'h0, 32'hBEEF});
      chk("sst_cycles", cycles, 3);
      chk("sst_nwe", n_we, 1);
      chk("sst_addr", we_addr[0], 32'h80);
      chk("sst_data", we_data[0], 32'hBEEF);

      // Address wrap, store wins over load.
      access(1, 1, 1, 32'hFFFF_FFF8, {32'h4, 32'h3, 32'h2, 32'h1});
      chk("wrap_cycles", cycles, 6);
      chk("wrap_nre", n_re, 0);
      chk("wrap_nwe", n_we, 4);
      chk("wrap_a0", we_addr[0], 32'hFFFF_FFF8);
      chk("wrap_a1", we_addr[1], 32'hFFFF_FFFC);
      chk("wrap_a2", we_addr[2], 32'h0);
      chk("wrap_a3", we_addr[3], 32'h4);
      chk("rdata_hold", rdata, {32'h2A9, 32'h2AD, 32'h2A1, 32'hDEAD});

      // Reset in the middle of a vector store.
      begin
         logic seen;
         seen = 1'b0;
         wr_mem = 1; rd_mem = 0; is_vec = 1; base_addr = 32'h300; wdata = {32'hD, 32'hC, 32'hB, 32'hA};
         #1;
         for (int c = 0; c < 10; c++) begin
            if (mem.mem_we && mem.mem_addr == 32'h304) begin seen = 1'b1; break; end
            @(posedge clk); #1;
         end
         chk("mid_beat1_seen", seen, 1);
         #2 reset = 1'b0;
         #1;
         chk("mid_stall", stall, 0);
         chk("mid_we", mem.mem_we, 0);
         chk("mid_done", done, 0);
         chk("mid_addr", mem.mem_addr, 0);
         chk("mid_rdata", rdata, 0);
         wr_mem = 0; is_vec = 0; base_addr = '0; wdata = '0;
         @(negedge clk); reset = 1'b1;
         @(posedge clk); #1;
         chk("rel_stall", stall, 0);
         @(posedge clk); #1;
         chk("rel_we", mem.mem_we, 0);
         chk("rel_stall2", stall, 0);
      end

      // Back-to-back store then load.
      access(1, 0, 1, 32'h500, {32'h8, 32'h7, 32'h6, 32'h5});
      chk("b2b_st_cycles", cycles, 6);
      chk("b2b_st_nwe", n_we, 4);
      access(0, 1, 1, 32'h200, '0);
      chk("b2b_gap", acc_cyc - last_we_cyc, 2);
      chk("b2b_ld_cycles", cycles, 7);
      chk("b2b_ld_nre", n_re, 4);
      chk("b2b_rdata", rdata, {32'h2A9, 32'h2AD, 32'h2A1, 32'h2A5});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
